axi_burst_reader: RTL and testbench

Master-side AXI read-burst engine: the initiator that drives the INCR read bursts whose beats the SRAM-side slave counts and terminates. It accepts a single (address, length) request from a local client, issues one AR transaction, counts the returning R beats against the requested length, and forwards each beat to the client with its index. It checks `RLAST` and `RRESP` and reports completion and error on a one-cycle pulse. It sits between cache-fill/DMA logic and the AXI interconnect.

---
 rtl/axi_burst_reader_if.sv | 33 +++
 rtl/axi_burst_reader.sv | 83 ++++++++
 tb/tb_axi_burst_reader.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/axi_burst_reader_if.sv
// axi_burst_reader_if: client request, AXI AR/R channels and beat/completion outputs of axi_burst_reader
interface axi_burst_reader_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [3:0]        req_len;
    logic [ADDR_W-1:0] araddr;
    logic [3:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;
    logic              beat_valid;
    logic [DATA_W-1:0] beat_data;
    logic [3:0]        beat_idx;
    logic              done;
    logic              err;
    modport master (
        input  req_valid, req_addr, req_len, arready, rdata, rresp, rlast, rvalid,
        output req_ready, araddr, arlen, arsize, arburst, arvalid, rready,
               beat_valid, beat_data, beat_idx, done, err
    );
    modport slave (
        output req_valid, req_addr, req_len, arready, rdata, rresp, rlast, rvalid,
        input  req_ready, araddr, arlen, arsize, arburst, arvalid, rready,
               beat_valid, beat_data, beat_idx, done, err
    );
endinterface

// File: rtl/axi_burst_reader.sv
// axi_burst_reader: AXI INCR read-burst master; define BURST_RD_RESP_CHK_EN to flag non-OKAY rresp as err
module axi_burst_reader #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic clk,
    input logic rst,
    axi_burst_reader_if.master bus
);
`ifdef BURST_RD_RESP_CHK_EN
    localparam bit RESP_CHK = 1'b1;
`else
    localparam bit RESP_CHK = 1'b0;
`endif
    typedef enum logic [2:0] {IDLE, ADDR, DATA, DRAIN, DONE} state_t;
    state_t            state, state_n;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        len_q, cnt, idx_q;
    logic [DATA_W-1:0] data_q;
    logic              beat_q, err_q;
    logic              take, beat, last_exp, early, late, bad;
    assign take     = state == IDLE && bus.req_valid;
    assign beat     = state == DATA && bus.rvalid;
    assign last_exp = cnt == len_q;
    assign early    = beat && bus.rlast && !last_exp;
    assign late     = beat && !bus.rlast && last_exp;
    assign bad      = RESP_CHK && (state == DATA || state == DRAIN) && bus.rvalid && bus.rresp != 2'b00;
    assign bus.araddr     = addr_q;
    assign bus.arlen      = len_q;
    assign bus.arsize     = 3'b010;
    assign bus.arburst    = 2'b01;
    assign bus.beat_valid = beat_q;
    assign bus.beat_data  = data_q;
    assign bus.beat_idx   = idx_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = bus.req_valid ? ADDR : IDLE;
            ADDR:    state_n = bus.arready ? DATA : ADDR;
            DATA:    state_n = !bus.rvalid ? DATA : bus.rlast ? DONE : last_exp ? DRAIN : DATA;
            DRAIN:   state_n = bus.rvalid && bus.rlast ? DONE : DRAIN;
            default: state_n = IDLE;
        endcase
    end
    always_comb begin
        bus.req_ready = state == IDLE;
        bus.arvalid   = state == ADDR;
        bus.rready    = state == DATA || state == DRAIN;
        bus.done      = state == DONE;
        bus.err       = state == DONE && err_q;
    end
    // cnt stops at len_q; a late-last burst leaves DATA instead of wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
            len_q  <= '0;
            cnt    <= '0;
            idx_q  <= '0;
            data_q <= '0;
            beat_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            beat_q <= beat;
            if (beat) begin
                data_q <= bus.rdata;
                idx_q  <= cnt;
            end
            if (take) begin
                addr_q <= bus.req_addr;
                len_q  <= bus.req_len;
                cnt    <= '0;
                err_q  <= 1'b0;
            end else begin
                if (beat && !bus.rlast && !last_exp) cnt <= cnt + 4'd1;
                if (early || late || bad) err_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_axi_burst_reader.sv
// tb_axi_burst_reader: directed self-checking bench for axi_burst_reader
module tb_axi_burst_reader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   failed = 0;
`ifdef BURST_RD_RESP_CHK_EN
    localparam logic RESP_ERR = 1'b1;
`else
    localparam logic RESP_ERR = 1'b0;
`endif
    axi_burst_reader_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    axi_burst_reader #(.ADDR_W(32), .DATA_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic chk_beat(input string tag, input logic v, input logic [31:0] d, input logic [3:0] i);
        chk({tag, ".valid"}, 32'(bus.beat_valid), 32'(v));
        if (v) begin
            chk({tag, ".data"}, bus.beat_data, d);
            chk({tag, ".idx"}, 32'(bus.beat_idx), 32'(i));
        end
    endtask
    task automatic chk_done(input string tag, input logic d, input logic e);
        chk({tag, ".done"}, 32'(bus.done), 32'(d));
        chk({tag, ".err"}, 32'(bus.err), 32'(e));
    endtask
    task automatic start(input string tag, input logic [31:0] addr, input logic [3:0] len, input int ar_wait);
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        bus.req_len   = len;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_len   = '0;
        chk({tag, ".arvalid"}, 32'(bus.arvalid), 32'd1);
        chk({tag, ".req_ready"}, 32'(bus.req_ready), 32'd0);
        chk({tag, ".araddr"}, bus.araddr, addr);
        chk({tag, ".arlen"}, 32'(bus.arlen), 32'(len));
        for (int k = 0; k < ar_wait; k++) begin
            @(negedge clk);
            chk({tag, ".arvalid_hold"}, 32'(bus.arvalid), 32'd1);
            chk({tag, ".araddr_hold"}, bus.araddr, addr);
        end
        bus.arready = 1'b1;
        @(negedge clk);
        bus.arready = 1'b0;
        chk({tag, ".rready"}, 32'(bus.rready), 32'd1);
        chk({tag, ".arvalid_low"}, 32'(bus.arvalid), 32'd0);
    endtask
    task automatic beat(input logic [31:0] d, input logic last, input logic [1:0] resp);
        bus.rvalid = 1'b1;
        bus.rdata  = d;
        bus.rlast  = last;
        bus.rresp  = resp;
        @(negedge clk);
        bus.rvalid = 1'b0;
        bus.rlast  = 1'b0;
        bus.rresp  = 2'b00;
        bus.rdata  = '0;
    endtask
    initial begin
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_len   = '0;
        bus.arready   = 1'b0;
        bus.rdata     = '0;
        bus.rresp     = 2'b00;
        bus.rlast     = 1'b0;
        bus.rvalid    = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst.req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst.arvalid", 32'(bus.arvalid), 32'd0);
        chk("rst.rready", 32'(bus.rready), 32'd0);
        chk_done("rst", 1'b0, 1'b0);
        chk("rst.beat_valid", 32'(bus.beat_valid), 32'd0);
        chk("rst.araddr", bus.araddr, 32'd0);
        chk("rst.arlen", 32'(bus.arlen), 32'd0);
        chk("rst.beat_data", bus.beat_data, 32'd0);
        chk("rst.beat_idx", 32'(bus.beat_idx), 32'd0);
        chk("rst.arsize", 32'(bus.arsize), 32'd2);
        chk("rst.arburst", 32'(bus.arburst), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        chk("idle.rvalid_ignored", 32'(bus.beat_valid), 32'd0);
        bus.rvalid = 1'b0;
        // basic burst
        start("basic", 32'h100, 4'd3, 0);
        beat(32'hA0, 1'b0, 2'b00); chk_beat("basic.b0", 1'b1, 32'hA0, 4'd0); chk_done("basic.b0", 1'b0, 1'b0);
        beat(32'hA1, 1'b0, 2'b00); chk_beat("basic.b1", 1'b1, 32'hA1, 4'd1);
        beat(32'hA2, 1'b0, 2'b00); chk_beat("basic.b2", 1'b1, 32'hA2, 4'd2);
        beat(32'hA3, 1'b1, 2'b00); chk_beat("basic.b3", 1'b1, 32'hA3, 4'd3); chk_done("basic.end", 1'b1, 1'b0);
        @(negedge clk);
        chk_done("basic.after", 1'b0, 1'b0);
        chk("basic.req_ready", 32'(bus.req_ready), 32'd1);
        chk_beat("basic.after", 1'b0, 32'h0, 4'd0);
        // stall tolerance
        start("stall", 32'h200, 4'd1, 5);
        @(negedge clk); chk_beat("stall.gap0", 1'b0, 32'h0, 4'd0);
        @(negedge clk); chk_beat("stall.gap1", 1'b0, 32'h0, 4'd0);
        beat(32'hB0, 1'b0, 2'b00); chk_beat("stall.b0", 1'b1, 32'hB0, 4'd0);
        @(negedge clk); chk_beat("stall.gap2", 1'b0, 32'h0, 4'd0);
        @(negedge clk); chk_beat("stall.gap3", 1'b0, 32'h0, 4'd0); chk_done("stall.gap3", 1'b0, 1'b0);
        beat(32'hB1, 1'b1, 2'b00); chk_beat("stall.b1", 1'b1, 32'hB1, 4'd1); chk_done("stall.end", 1'b1, 1'b0);
        @(negedge clk);
        chk_beat("stall.after", 1'b0, 32'h0, 4'd0);
        // early last
        start("early", 32'h300, 4'd7, 0);
        beat(32'hC0, 1'b0, 2'b00); chk_beat("early.b0", 1'b1, 32'hC0, 4'd0);
        beat(32'hC1, 1'b0, 2'b00); chk_beat("early.b1", 1'b1, 32'hC1, 4'd1);
        beat(32'hC2, 1'b1, 2'b00); chk_beat("early.b2", 1'b1, 32'hC2, 4'd2); chk_done("early.end", 1'b1, 1'b1);
        @(negedge clk);
        chk_done("early.after", 1'b0, 1'b0);
        chk("early.req_ready", 32'(bus.req_ready), 32'd1);
        // late last
        start("late", 32'h400, 4'd1, 0);
        beat(32'hD0, 1'b0, 2'b00); chk_beat("late.b0", 1'b1, 32'hD0, 4'd0);
        beat(32'hD1, 1'b0, 2'b00); chk_beat("late.b1", 1'b1, 32'hD1, 4'd1); chk_done("late.b1", 1'b0, 1'b0);
        beat(32'hD2, 1'b0, 2'b00); chk_beat("late.b2", 1'b0, 32'h0, 4'd0); chk_done("late.b2", 1'b0, 1'b0);
        chk("late.drain_rready", 32'(bus.rready), 32'd1);
        beat(32'hD3, 1'b1, 2'b00); chk_beat("late.b3", 1'b0, 32'h0, 4'd0); chk_done("late.end", 1'b1, 1'b1);
        @(negedge clk);
        chk("late.req_ready", 32'(bus.req_ready), 32'd1);
        // response check
        start("resp", 32'h500, 4'd2, 0);
        beat(32'hE0, 1'b0, 2'b00); chk_beat("resp.b0", 1'b1, 32'hE0, 4'd0);
        beat(32'hE1, 1'b0, 2'b10); chk_beat("resp.b1", 1'b1, 32'hE1, 4'd1);
        beat(32'hE2, 1'b1, 2'b00); chk_beat("resp.b2", 1'b1, 32'hE2, 4'd2); chk_done("resp.end", 1'b1, RESP_ERR);
        @(negedge clk);
        // reset mid-burst
        start("mid", 32'h600, 4'd5, 0);
        beat(32'hF0, 1'b0, 2'b00);
        beat(32'hF1, 1'b0, 2'b00); chk_beat("mid.b1", 1'b1, 32'hF1, 4'd1);
        rst = 1'b1;
        #1;
        chk("mid.req_ready", 32'(bus.req_ready), 32'd1);
        chk("mid.rready", 32'(bus.rready), 32'd0);
        chk("mid.beat_valid", 32'(bus.beat_valid), 32'd0);
        chk("mid.beat_data", bus.beat_data, 32'd0);
        chk("mid.beat_idx", 32'(bus.beat_idx), 32'd0);
        chk("mid.araddr", bus.araddr, 32'd0);
        chk("mid.arlen", 32'(bus.arlen), 32'd0);
        chk_done("mid.rst", 1'b0, 1'b0);
        @(negedge clk);
        chk_done("mid.rst_hold", 1'b0, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk_done("mid.post", 1'b0, 1'b0);
        start("len0", 32'h700, 4'd0, 0);
        beat(32'h77, 1'b1, 2'b00); chk_beat("len0.b0", 1'b1, 32'h77, 4'd0); chk_done("len0.end", 1'b1, 1'b0);
        @(negedge clk);
        chk_done("len0.after", 1'b0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
